// File: rtl/dacspi_ser.sv
// Multi-channel serial DAC driver: captures NCH words, shifts each enabled one
// MSB-first in its own chip-select frame, then pulses a common load strobe.
module dacspi_ser #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2,
  parameter int DIV   = 1
) (
  input  logic                   dacclk,
  input  logic                   dacrst,
  input  logic                   dacdav,
  input  logic [NCH*WIDTH-1:0]   dacdata,
  input  logic [NCH-1:0]         dacmask,
  output logic                   davdac,
  output logic                   dacbusy,
  output logic                   dacout,
  output logic                   dacsck,
  output logic                   daccs,
  output logic                   dacld
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FRAME = 3'd1,
    GAP   = 3'd2,
    LOAD  = 3'd3,
    ACK   = 3'd4
  } state_t;

  state_t               state_q;
  logic [NCH*WIDTH-1:0] data_q;
  logic [NCH-1:0]       pend_q;
  logic                 sent_q;
  logic [WIDTH-1:0]     word_q;
  logic [BW-1:0]        bit_q;
  logic [7:0]           div_q;
  logic                 davdac_q;
  logic                 busy_q;
  logic                 dout_q;
  logic                 sck_q;
  logic                 cs_q;
  logic                 ld_q;

  logic [NCH-1:0]       src_mask_s;
  logic [NCH*WIDTH-1:0] src_data_s;
  logic [CW-1:0]        ch_s;
  logic [WIDTH-1:0]     word_s;
  logic [NCH-1:0]       pend_next_s;
  logic                 has_s;

  function automatic logic [CW-1:0] first_ch(input logic [NCH-1:0] m);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = CW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next frame source: the live inputs at capture, the pending set afterwards.
  always_comb begin
    src_mask_s  = (state_q == IDLE) ? dacmask : pend_q;
    src_data_s  = (state_q == IDLE) ? dacdata : data_q;
    has_s       = |src_mask_s;
    ch_s        = first_ch(src_mask_s);
    word_s      = src_data_s[int'(ch_s)*WIDTH +: WIDTH];
    pend_next_s = src_mask_s & ~(NCH'(1) << ch_s);
  end

  // Transfer sequencer with registered serial, strobe and handshake outputs.
  always_ff @(posedge dacclk or posedge dacrst) begin
    if (dacrst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      pend_q   <= '0;
      sent_q   <= 1'b0;
      word_q   <= '0;
      bit_q    <= '0;
      div_q    <= 8'd0;
      davdac_q <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= 1'b0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      ld_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dacdav && !davdac_q) begin
            data_q <= dacdata;
            busy_q <= 1'b1;
            sent_q <= has_s;
            pend_q <= pend_next_s;
            if (has_s) begin
              state_q <= FRAME;
              cs_q    <= 1'b0;
              sck_q   <= 1'b0;
              dout_q  <= word_s[WIDTH-1];
              word_q  <= word_s;
              bit_q   <= BW'(WIDTH - 1);
              div_q   <= 8'(DIV - 1);
            end else begin
              // Empty mask: one GAP cycle then straight to ACK without a strobe.
              state_q <= GAP;
              div_q   <= 8'd0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        FRAME: begin
          if (!dacdav) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            dout_q  <= 1'b0;
            div_q   <= 8'd0;
            bit_q   <= '0;
          end else if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else if (!sck_q) begin
            sck_q <= 1'b1;
            div_q <= 8'(DIV - 1);
          end else if (bit_q != '0) begin
            sck_q  <= 1'b0;
            bit_q  <= bit_q - 1'b1;
            dout_q <= word_q[bit_q - 1'b1];
            div_q  <= 8'(DIV - 1);
          end else begin
            state_q <= GAP;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            dout_q  <= 1'b0;
            div_q   <= 8'(DIV - 1);
          end
        end
        GAP: begin
          if (!dacdav) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            div_q   <= 8'd0;
          end else if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else if (has_s) begin
            state_q <= FRAME;
            pend_q  <= pend_next_s;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            dout_q  <= word_s[WIDTH-1];
            word_q  <= word_s;
            bit_q   <= BW'(WIDTH - 1);
            div_q   <= 8'(DIV - 1);
          end else if (sent_q) begin
            state_q <= LOAD;
            ld_q    <= 1'b1;
            div_q   <= 8'(DIV - 1);
          end else begin
            state_q  <= ACK;
            davdac_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (!dacdav) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ld_q    <= 1'b0;
            div_q   <= 8'd0;
          end else if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else begin
            state_q  <= ACK;
            ld_q     <= 1'b0;
            davdac_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        ACK: begin
          if (!dacdav) begin
            state_q  <= IDLE;
            davdac_q <= 1'b0;
          end else begin
            state_q <= ACK;
          end
        end
        default: begin
          state_q  <= IDLE;
          davdac_q <= 1'b0;
          busy_q   <= 1'b0;
          dout_q   <= 1'b0;
          sck_q    <= 1'b0;
          cs_q     <= 1'b1;
          ld_q     <= 1'b0;
          div_q    <= 8'd0;
          bit_q    <= '0;
        end
      endcase
    end
  end

  assign davdac  = davdac_q;
  assign dacbusy = busy_q;
  assign dacout  = dout_q;
  assign dacsck  = sck_q;
  assign daccs   = cs_q;
  assign dacld   = ld_q;

endmodule
